fifo_sync_param: RTL and testbench

Parametrised single-clock FIFO, the next-generation buffer for streaming datapaths between producer and consumer blocks in one clock domain. It uses all DEPTH entries via an occupancy counter. Any DEPTH ≥ 2 is supported, not only powers of two. It adds programmable almost-full/almost-empty flags, an occupancy count, overflow/underflow pulses, and a selectable first-word-fall-through (FWFT) output mode.

---
 rtl/fifo_pkg.sv | 5 +
 rtl/fifo_sync_param_if.sv | 29 ++
 rtl/fifo_mem.sv | 22 ++
 rtl/fifo_sync_param.sv | 105 ++++++++++
 tb/tb_fifo_sync_param.sv | 167 ++++++++++++++++
 5 files changed

// File: rtl/fifo_pkg.sv
// Constants shared by the FIFO family.
package fifo_pkg;
    localparam int FIFO_MODE_STD  = 0;
    localparam int FIFO_MODE_FWFT = 1;
endpackage

// File: rtl/fifo_sync_param_if.sv
// Producer/consumer bus of the single-clock FIFO. The slave modport is the FIFO side.
interface fifo_sync_param_if #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 32
);
    localparam int CNT_WIDTH = $clog2(DEPTH + 1);

    logic                  write_en;
    logic [DATA_WIDTH-1:0] data_in;
    logic                  read_en;
    logic [DATA_WIDTH-1:0] data_out;
    logic                  empty;
    logic                  full;
    logic                  almost_empty;
    logic                  almost_full;
    logic [CNT_WIDTH-1:0]  count;
    logic                  overflow;
    logic                  underflow;

    modport master (
        output write_en, data_in, read_en,
        input  data_out, empty, full, almost_empty, almost_full, count, overflow, underflow
    );

    modport slave (
        input  write_en, data_in, read_en,
        output data_out, empty, full, almost_empty, almost_full, count, overflow, underflow
    );
endinterface

// File: rtl/fifo_mem.sv
// DEPTH x DATA_WIDTH register array: synchronous write, asynchronous read, no reset.
module fifo_mem #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 32
) (
    input  logic                          clk,
    input  logic                          we_i,
    input  logic [$clog2(DEPTH)-1:0]      waddr_i,
    input  logic [DATA_WIDTH-1:0]         wdata_i,
    input  logic [$clog2(DEPTH)-1:0]      raddr_i,
    output logic [DATA_WIDTH-1:0]         rdata_o
);
    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];
endmodule

// File: rtl/fifo_sync_param.sv
// Single-clock FIFO, any DEPTH>=2; standard mode reads in 1 cycle, FWFT shows head after the write edge.
// Writes are refused when full unless a read retires the same edge; refused requests pulse overflow/underflow.
module fifo_sync_param
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 32,
    parameter int AF_THRESH  = DEPTH - 2,
    parameter int AE_THRESH  = 2,
    parameter int FWFT       = FIFO_MODE_STD
) (
    input  logic             clk,
    input  logic             reset,
    fifo_sync_param_if.slave fifo_if
);
    localparam int ADDR_WIDTH = $clog2(DEPTH);
    localparam int CNT_WIDTH  = $clog2(DEPTH + 1);

    logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
    logic                  ovf_q, ovf_d;
    logic                  udf_q, udf_d;
    logic                  empty, full;
    logic                  wr_acc, rd_acc;
    logic [DATA_WIDTH-1:0] mem_rdata;

    assign empty = (cnt_q == '0);
    assign full  = (cnt_q == CNT_WIDTH'(DEPTH));

    // A read retiring the head frees a slot for a same-edge write even when full.
    assign rd_acc = fifo_if.read_en && !empty;
    assign wr_acc = fifo_if.write_en && (!full || rd_acc);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        ovf_d    = fifo_if.write_en && !wr_acc;
        udf_d    = fifo_if.read_en && !rd_acc;
        if (wr_acc) begin
            wr_ptr_d = (wr_ptr_q == ADDR_WIDTH'(DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
        end
        if (rd_acc) begin
            rd_ptr_d = (rd_ptr_q == ADDR_WIDTH'(DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
        end
        case ({wr_acc, rd_acc})
            2'b10:   cnt_d = cnt_q + CNT_WIDTH'(1);
            2'b01:   cnt_d = cnt_q - CNT_WIDTH'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            ovf_q    <= 1'b0;
            udf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            ovf_q    <= ovf_d;
            udf_q    <= udf_d;
        end
    end

    fifo_mem #(
        .DATA_WIDTH(DATA_WIDTH),
        .DEPTH     (DEPTH)
    ) u_mem (
        .clk    (clk),
        .we_i   (wr_acc && !reset),
        .waddr_i(wr_ptr_q),
        .wdata_i(fifo_if.data_in),
        .raddr_i(rd_ptr_q),
        .rdata_o(mem_rdata)
    );

    generate
        if (FWFT == FIFO_MODE_FWFT) begin : g_fwft
            assign fifo_if.data_out = mem_rdata;
        end else begin : g_std
            logic [DATA_WIDTH-1:0] dout_q;
            always_ff @(posedge clk) begin
                if (reset) begin
                    dout_q <= '0;
                end else if (rd_acc) begin
                    dout_q <= mem_rdata;
                end
            end
            assign fifo_if.data_out = dout_q;
        end
    endgenerate

    assign fifo_if.empty        = empty;
    assign fifo_if.full         = full;
    assign fifo_if.almost_empty = (cnt_q <= CNT_WIDTH'(AE_THRESH));
    assign fifo_if.almost_full  = (cnt_q >= CNT_WIDTH'(AF_THRESH));
    assign fifo_if.count        = cnt_q;
    assign fifo_if.overflow     = ovf_q;
    assign fifo_if.underflow    = udf_q;
endmodule

// File: tb/tb_fifo_sync_param.sv
// Bench for fifo_sync_param: standard and FWFT instances driven identically, compared to a queue model.
module tb_fifo_sync_param;
    import fifo_pkg::*;

    localparam int DW    = 8;
    localparam int DEPTH = 6;
    localparam int AF    = 4;
    localparam int AE    = 1;

    logic clk;
    logic reset;
    int   total;
    int   bad;

    fifo_sync_param_if #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) if_std ();
    fifo_sync_param_if #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) if_fwft ();

    fifo_sync_param #(
        .DATA_WIDTH(DW), .DEPTH(DEPTH), .AF_THRESH(AF), .AE_THRESH(AE), .FWFT(FIFO_MODE_STD)
    ) dut_std (
        .clk    (clk),
        .reset  (reset),
        .fifo_if(if_std)
    );

    fifo_sync_param #(
        .DATA_WIDTH(DW), .DEPTH(DEPTH), .AF_THRESH(AF), .AE_THRESH(AE), .FWFT(FIFO_MODE_FWFT)
    ) dut_fwft (
        .clk    (clk),
        .reset  (reset),
        .fifo_if(if_fwft)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model state
    logic [DW-1:0] model_q[$];
    logic [DW-1:0] exp_dout;
    logic          exp_ovf;
    logic          exp_udf;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // One clock: drive inputs, advance the model on the edge, check all outputs just after it.
    task automatic cycle(input logic we, input logic [DW-1:0] din, input logic re, input logic rst);
        int  sz;
        bit  ra;
        bit  wa;
        reset            = rst;
        if_std.write_en  = we;
        if_std.data_in   = din;
        if_std.read_en   = re;
        if_fwft.write_en = we;
        if_fwft.data_in  = din;
        if_fwft.read_en  = re;
        @(posedge clk);
        if (rst) begin
            model_q.delete();
            exp_dout = '0;
            exp_ovf  = 1'b0;
            exp_udf  = 1'b0;
        end else begin
            sz      = model_q.size();
            ra      = re && (sz > 0);
            wa      = we && ((sz < DEPTH) || ra);
            exp_ovf = we && !wa;
            exp_udf = re && !ra;
            if (ra) exp_dout = model_q.pop_front();
            if (wa) model_q.push_back(din);
        end
        #1;
        sz = model_q.size();
        check("std_count", 32'(if_std.count), 32'(sz));
        check("std_empty", 32'(if_std.empty), 32'(sz == 0));
        check("std_full", 32'(if_std.full), 32'(sz == DEPTH));
        check("std_aempty", 32'(if_std.almost_empty), 32'(sz <= AE));
        check("std_afull", 32'(if_std.almost_full), 32'(sz >= AF));
        check("std_ovf", 32'(if_std.overflow), 32'(exp_ovf));
        check("std_udf", 32'(if_std.underflow), 32'(exp_udf));
        check("std_dout", 32'(if_std.data_out), 32'(exp_dout));
        check("fwft_count", 32'(if_fwft.count), 32'(sz));
        check("fwft_empty", 32'(if_fwft.empty), 32'(sz == 0));
        check("fwft_ovf", 32'(if_fwft.overflow), 32'(exp_ovf));
        check("fwft_udf", 32'(if_fwft.underflow), 32'(exp_udf));
        if (sz > 0) check("fwft_dout", 32'(if_fwft.data_out), 32'(model_q[0]));
    endtask

    initial begin
        int pw;
        int pr;
        total    = 0;
        bad      = 0;
        exp_dout = '0;
        exp_ovf  = 1'b0;
        exp_udf  = 1'b0;

        cycle(1'b0, 8'h00, 1'b0, 1'b1);
        check("rst_count", 32'(if_std.count), 32'd0);
        check("rst_ae", 32'(if_std.almost_empty), 32'd1);
        cycle(1'b0, 8'h00, 1'b0, 1'b0);

        // Fill 0x01..0x06; almost_full after 4th write, full after 6th
        for (int i = 1; i <= DEPTH; i++) begin
            cycle(1'b1, 8'(i), 1'b0, 1'b0);
            if (i == 4) check("af_at_4", 32'(if_std.almost_full), 32'd1);
        end
        check("full_at_6", 32'(if_std.full), 32'd1);
        cycle(1'b1, 8'h77, 1'b0, 1'b0);
        check("ovf_pulse", 32'(if_std.overflow), 32'd1);
        cycle(1'b1, 8'h88, 1'b1, 1'b0);
        check("full_rw_ovf", 32'(if_std.overflow), 32'd0);
        check("full_rw_dout", 32'(if_std.data_out), 32'h01);
        for (int i = 0; i < DEPTH; i++) cycle(1'b0, 8'h00, 1'b1, 1'b0);
        check("last_is_88", 32'(if_std.data_out), 32'h88);

        // Underflow on empty, then simultaneous read+write into empty
        cycle(1'b0, 8'h00, 1'b1, 1'b0);
        check("udf_pulse", 32'(if_std.underflow), 32'd1);
        cycle(1'b1, 8'hAA, 1'b1, 1'b0);
        check("empty_rw_cnt", 32'(if_std.count), 32'd1);
        check("empty_rw_udf", 32'(if_std.underflow), 32'd1);
        cycle(1'b0, 8'h00, 1'b1, 1'b0);
        check("aa_read", 32'(if_std.data_out), 32'hAA);

        // Wrap-around at occupancy 3
        for (int i = 0; i < 3; i++) cycle(1'b1, 8'(8'h10 + i), 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) cycle(1'b1, 8'(8'h20 + i), 1'b1, 1'b0);
        check("wrap_cnt", 32'(if_std.count), 32'd3);
        for (int i = 0; i < 3; i++) cycle(1'b0, 8'h00, 1'b1, 1'b0);

        // FWFT first-word visibility
        cycle(1'b1, 8'h5A, 1'b0, 1'b0);
        check("fwft_5a", 32'(if_fwft.data_out), 32'h5A);
        cycle(1'b0, 8'h00, 1'b1, 1'b0);
        check("fwft_pop_empty", 32'(if_fwft.empty), 32'd1);

        // Reset mid-traffic at count 4
        for (int i = 0; i < 4; i++) cycle(1'b1, 8'(8'h40 + i), 1'b0, 1'b0);
        cycle(1'b1, 8'hEE, 1'b1, 1'b1);
        check("mid_rst_cnt", 32'(if_std.count), 32'd0);
        check("mid_rst_dout", 32'(if_std.data_out), 32'd0);

        // Randomized traffic with changing write/read bias
        for (int blk = 0; blk < 6; blk++) begin
            pw = (blk % 2 == 0) ? 75 : 30;
            pr = (blk % 2 == 0) ? 30 : 75;
            if (blk >= 4) begin
                pw = 55;
                pr = 55;
            end
            for (int i = 0; i < 80; i++) begin
                cycle($urandom_range(0, 99) < pw, 8'($urandom), $urandom_range(0, 99) < pr,
                      $urandom_range(0, 199) == 0);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
